// File: rtl/snake_pkg.sv
// Shared definitions for the snake input stage: one-hot direction codes,
// the reversal helper and the tick FSM state type.
package snake_pkg;

   localparam logic [3:0] DIR_NONE  = 4'b0000;
   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_LEFT  = 4'b0010;
   localparam logic [3:0] DIR_DOWN  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic [3:0] dir_opposite(input logic [3:0] dir);
      logic [3:0] opp;
      case (dir)
         DIR_UP:    opp = DIR_DOWN;
         DIR_LEFT:  opp = DIR_RIGHT;
         DIR_DOWN:  opp = DIR_UP;
         DIR_RIGHT: opp = DIR_LEFT;
         default:   opp = DIR_NONE;
      endcase
      return opp;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-flop synchroniser, stability-count debouncer and a
// single-cycle pulse on each accepted press (debounced rising edge).
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_q, sync2_q;
   logic             deb_q, deb_d;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (sync2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         deb_d = ~deb_q;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Synchroniser, debounce state and previous-level register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         prev_q  <= deb_q;
         cnt_q   <= cnt_d;
      end
   end

   assign press = deb_q & ~prev_q;

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake input stage: debounced w/a/s/d presses become a pending direction
// (reversals dropped) that is committed to direcao on each periodic move tick.
module snake_input_ctrl
   import snake_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TICK_CYCLES     = 8,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       w,
   input  logic       a,
   input  logic       s,
   input  logic       d,
   output logic [3:0] direcao,
   output logic       move_tick,
   output logic       pending_v
);

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [3:0]       btn_raw_s;
   logic [3:0]       press_s;
   logic [3:0]       req_s;
   logic             leave_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic [3:0]       dir_q, dir_d;
   logic [3:0]       pdir_q, pdir_d;
   logic             pv_q, pv_d;

   // Bit order matches the one-hot direction encoding (w=up ... d=right)
   assign btn_raw_s = {d, s, a, w};

   for (genvar i = 0; i < 4; i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_btn (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_raw (btn_raw_s[i]),
         .press   (press_s[i])
      );
   end

   assign leave_s = (state_q == RUN) && !start;

   // Next-state: FSM, tick counter, commit on tick, then filter the new request
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      pdir_d  = pdir_q;
      pv_d    = pv_q;
      tick_d  = 1'b0;

      if (press_s[0]) begin
         req_s = DIR_UP;
      end else if (press_s[1]) begin
         req_s = DIR_LEFT;
      end else if (press_s[2]) begin
         req_s = DIR_DOWN;
      end else if (press_s[3]) begin
         req_s = DIR_RIGHT;
      end else begin
         req_s = DIR_NONE;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (!start) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == TICK_LAST) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // The tick commits first so a same-cycle request is judged against it
      if (tick_q && pv_q) begin
         dir_d = pdir_q;
         pv_d  = 1'b0;
      end else begin
         dir_d = dir_q;
      end

      if (leave_s) begin
         pv_d = 1'b0;
      end else if ((req_s != DIR_NONE) &&
                   ((dir_d == DIR_NONE) || (req_s != dir_opposite(dir_d)))) begin
         pdir_d = req_s;
         pv_d   = 1'b1;
      end else begin
         pdir_d = pdir_q;
      end

      tick_d = (state_d == RUN) && (cnt_d == TICK_LAST);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         dir_q   <= DIR_NONE;
         pdir_q  <= DIR_NONE;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         dir_q   <= dir_d;
         pdir_q  <= pdir_d;
         pv_q    <= pv_d;
      end
   end

   assign direcao   = dir_q;
   assign move_tick = tick_q;
   assign pending_v = pv_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Self-checking bench for snake_input_ctrl: directed scenarios plus a random
// soak, compared cycle by cycle against a rule-level game model.
module tb_snake_input_ctrl;

   localparam int DB = 4;
   localparam int TK = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       w = 1'b0, a = 1'b0, s = 1'b0, d = 1'b0;
   logic [3:0] direcao;
   logic       move_tick;
   logic       pending_v;

   int n_checks = 0;
   int n_err    = 0;

   // Model state: pin sample window, debounced levels and game rules
   logic [3:0] m_hist [0:DB+1];
   logic [3:0] m_deb, m_prev;
   logic [3:0] m_dir, m_pdir;
   logic       m_pv, m_run, m_tick;
   int         m_age;
   logic [3:0] prev_obs;

   snake_input_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .TICK_CYCLES     (TK),
      .CNT_W           (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .w         (w),
      .a         (a),
      .s         (s),
      .d         (d),
      .direcao   (direcao),
      .move_tick (move_tick),
      .pending_v (pending_v)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int dir_idx(input logic [3:0] dir);
      int idx = -1;
      for (int i = 0; i < 4; i++) if (dir[i]) idx = i;
      return idx;
   endfunction

   // Up/left/down/right sit at indices 0..3, so opposites are two apart
   function automatic bit is_reverse(input logic [3:0] req, input logic [3:0] cur);
      if (cur == 4'b0000 || req == 4'b0000) return 1'b0;
      return ((dir_idx(req) + 2) % 4) == dir_idx(cur);
   endfunction

   task automatic model_reset();
      for (int j = 0; j <= DB + 1; j++) m_hist[j] = 4'b0000;
      m_deb = 4'b0000; m_prev = 4'b0000;
      m_dir = 4'b0000; m_pdir = 4'b0000;
      m_pv = 1'b0; m_run = 1'b0; m_tick = 1'b0; m_age = 0;
      prev_obs = 4'b0000;
   endtask

   task automatic model_step();
      logic [3:0] ev, req;
      bit         stable;
      ev = m_deb & ~m_prev;
      if (m_tick && m_pv) begin
         m_dir = m_pdir;
         m_pv  = 1'b0;
      end
      if (m_run && !start) begin
         m_run = 1'b0;
         m_pv  = 1'b0;
      end else begin
         req = 4'b0000;
         for (int i = 3; i >= 0; i--) begin
            if (ev[i]) begin
               req = 4'b0000;
               req[i] = 1'b1;
            end
         end
         if (req != 4'b0000 && !is_reverse(req, m_dir)) begin
            m_pdir = req;
            m_pv   = 1'b1;
         end
         if (m_run) m_age++;
         else if (start) begin
            m_run = 1'b1;
            m_age = 0;
         end
      end
      m_tick = m_run && ((m_age % TK) == TK - 1);
      for (int j = DB + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = {d, s, a, w};
      m_prev = m_deb;
      // A level flips once the last DB synchronised samples all disagree with it
      for (int b = 0; b < 4; b++) begin
         stable = 1'b1;
         for (int j = 2; j <= DB + 1; j++) if (m_hist[j][b] == m_deb[b]) stable = 1'b0;
         if (stable) m_deb[b] = ~m_deb[b];
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      check_val("direcao", 32'(direcao), 32'(m_dir));
      check_val("move_tick", 32'(move_tick), 32'(m_tick));
      check_val("pending_v", 32'(pending_v), 32'(m_pv));
      check_val("onehot", 32'($countones(direcao) <= 1), 32'd1);
      check_val("no_reverse", 32'(is_reverse(direcao, prev_obs)), 32'd0);
      prev_obs = direcao;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_dir", 32'(direcao), 32'd0);
      check_val("rst_tick", 32'(move_tick), 32'd0);
      check_val("rst_pend", 32'(pending_v), 32'd0);
      model_reset();
      {d, s, a, w} = 4'b0000;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic press(input logic [3:0] keys);
      {d, s, a, w} = keys;
      repeat (7) cyc();
      {d, s, a, w} = 4'b0000;
      cyc();
   endtask

   task automatic wait_tick();
      bit found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (move_tick) begin
            found = 1'b1;
            break;
         end
      end
      check_val("tick_seen", 32'(found), 32'd1);
      if (found) cyc();
   endtask

   initial begin
      bit exp_tick;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-cycle with buttons held and the game running
      {d, s, a, w} = 4'b1111;
      start = 1'b1;
      repeat (20) cyc();
      do_reset();

      // Bouncing w never qualifies; a held w does and commits on the first tick
      for (int i = 0; i < 10; i++) begin
         w = ~w;
         cyc();
         check_val("bounce_pend", 32'(pending_v), 32'd0);
      end
      w = 1'b0;
      repeat (8) cyc();
      press(4'b0001);
      check_val("held_pend", 32'(pending_v), 32'd1);
      start = 1'b1;
      wait_tick();
      check_val("first_dir", 32'(direcao), 32'h1);

      // Reversal dropped, perpendicular turn accepted
      press(4'b0100);
      check_val("rev_pend", 32'(pending_v), 32'd0);
      wait_tick();
      check_val("rev_dir", 32'(direcao), 32'h1);
      press(4'b0010);
      wait_tick();
      check_val("turn_dir", 32'(direcao), 32'h2);

      // Tick timing across stop and restart
      start = 1'b0;
      repeat (3) cyc();
      start = 1'b1;
      for (int n = 0; n < 28; n++) begin
         cyc();
         exp_tick = (n < 18) && ((n % TK) == TK - 1);
         check_val("tick_timing", 32'(move_tick), 32'(exp_tick));
         if (n == 17) start = 1'b0;
      end
      start = 1'b1;
      for (int n = 0; n < 9; n++) begin
         cyc();
         check_val("restart_tick", 32'(move_tick), 32'(n == 7));
      end

      // Simultaneous w+d from stopped, then a then d while idle
      do_reset();
      press(4'b1001);
      start = 1'b1;
      wait_tick();
      check_val("simul_dir", 32'(direcao), 32'h1);
      start = 1'b0;
      cyc();
      press(4'b0010);
      press(4'b1000);
      check_val("last_pend", 32'(pending_v), 32'd1);
      start = 1'b1;
      wait_tick();
      check_val("last_wins", 32'(direcao), 32'h8);

      // Press event lands on the tick edge: up commits, then left is judged against up
      start = 1'b0;
      cyc();
      press(4'b0001);
      start = 1'b1;
      cyc();
      cyc();
      a = 1'b1;
      repeat (6) cyc();
      check_val("coll_tick", 32'(move_tick), 32'd1);
      check_val("coll_pend_old", 32'(pending_v), 32'd1);
      cyc();
      check_val("coll_dir", 32'(direcao), 32'h1);
      check_val("coll_pend_new", 32'(pending_v), 32'd1);
      a = 1'b0;
      wait_tick();
      check_val("coll_next", 32'(direcao), 32'h2);

      // Random soak
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(5) == 0) begin
            if ($urandom_range(3) == 0) {d, s, a, w} = 4'($urandom_range(15));
            else begin
               {d, s, a, w} = 4'b0000;
               if ($urandom_range(1) == 0) begin
                  case ($urandom_range(3))
                     0: w = 1'b1;
                     1: a = 1'b1;
                     2: s = 1'b1;
                     default: d = 1'b1;
                  endcase
               end
            end
         end
         if ($urandom_range(59) == 0) start = ~start;
         if ($urandom_range(599) == 0) do_reset();
         else cyc();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
